sort_rx: RTL and testbench
==========================

SORT_RX -- requirements
Module: sort_rx

Interface
REQ-001 Parameter WIDTH, default WIDTH from the shared package, data word width in bits.
REQ-002 Parameter ADDRESS, default ADDRESS from the shared package; frame capacity is 2**ADDRESS words.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 idata  input  WIDTH  stream data from the sorter output (odata).
REQ-006 ivalid  input  1  stream valid (sorter ovalid).
REQ-007 ilast  input  1  last beat of frame (sorter olast).
REQ-008 iready  output  1  sink ready (drives sorter oready).
REQ-009 sink_en  input  1  1 = sink may accept beats; 0 = iready held low.
REQ-010 desc  input  1  1 = frame must be non-increasing, 0 = non-decreasing; sampled on first beat of frame.
REQ-011 frame_done  output  1  one-cycle pulse when a frame report is valid.
REQ-012 frame_len  output  ADDRESS+1  number of beats accepted in last completed frame.
REQ-013 order_err  output  1  last frame violated the ordering selected by desc.
REQ-014 err_index  output  ADDRESS+1  beat index (0-based) of first order violation; 0 if none.
REQ-015 overflow_err  output  1  last frame exceeded 2**ADDRESS beats.
REQ-016 first_data, last_data  output  WIDTH each  first and last accepted word of last frame.
REQ-017 frame_cnt  output  16  completed frames since reset, wraps 16'hFFFF -> 0.

Function
REQ-018 Beat accepted only in the cycle where ivalid=1 and iready=1; no other condition consumes data.
REQ-019 FSM states IDLE, RECV, REPORT; IDLE -> RECV on accepted non-last beat; IDLE -> REPORT on accepted beat with ilast=1; RECV -> REPORT on accepted beat with ilast=1; REPORT -> IDLE unconditionally after one cycle.
REQ-020 iready = sink_en in IDLE and RECV; iready = 0 in REPORT; iready is combinational from state and sink_en only, never from ivalid.
REQ-021 First beat in IDLE clears working length/error registers, latches desc, stores first_data, loads working count 1.
REQ-022 Each accepted beat after the first compares idata with the previous accepted word; desc=1 flags error if idata > previous, desc=0 if idata < previous; equal values never an error; comparison unsigned.
REQ-023 Only the first violation sets err_index; later violations leave it unchanged.
REQ-024 Working count saturates at 2**ADDRESS; a beat accepted when count already equals 2**ADDRESS sets overflow flag, beat still consumed, count not incremented.
REQ-025 frame_done pulses high exactly one cycle, in REPORT, i.e. one cycle after the ilast beat is accepted.
REQ-026 frame_len, order_err, err_index, overflow_err, first_data, last_data update together on entry to REPORT and hold until the next entry to REPORT.
REQ-027 frame_cnt increments by 1 in the REPORT cycle.
REQ-028 Single-beat frame (ilast on first beat): frame_len=1, order_err=0, first_data=last_data=idata.
REQ-029 sink_en dropping mid-frame only stalls (iready=0); frame state retained, no report generated.
REQ-030 ivalid asserted while in REPORT is not accepted; the beat is taken in the following IDLE cycle if still valid.

Reset
REQ-031 reset low asynchronously forces state IDLE; all outputs and internal registers to 0 except iready, which follows REQ-020 (equals sink_en).
REQ-032 Reset asserted mid-frame discards the partial frame; no frame_done, frame_cnt unchanged from 0.

Structure
REQ-033 WIDTH, ADDRESS and the receiver state enum (named distinctly from the sorter's states type) reside in the shared sort package.
REQ-034 Single flat module; no sub-module required.

Verification
REQ-035 WIDTH=8, desc=1, frame 9,7,7,3 (ilast on 3), sink_en=1 -> frame_done one cycle after last beat, frame_len=4, order_err=0, first_data=9, last_data=3, frame_cnt=1.
REQ-036 desc=1, frame 5,4,6,2,8 -> order_err=1, err_index=2, frame_len=5.
REQ-037 ADDRESS=3, 10-beat frame -> overflow_err=1, frame_len=8, all 10 beats consumed.
REQ-038 sink_en toggled 1,0,0,1 during 4-beat frame with ivalid held -> iready mirrors sink_en, no beat lost or duplicated, frame_len=4.
REQ-039 Back-to-back frames with ivalid held through REPORT -> iready=0 exactly one cycle, second frame's first beat accepted next cycle, frame_cnt=2.
REQ-040 reset pulsed low after 2 beats of a frame -> outputs 0, no frame_done; next 3-beat frame reports frame_len=3, frame_cnt=1.

Source files
------------

// File: rtl/sort_pkg.sv
// Shared sort package: default data/address widths and the receiver state type.
package sort_pkg;

  localparam int WIDTH   = 8;
  localparam int ADDRESS = 4;

  // The receiver needs its own state type, separate from the sorter's states.
  typedef enum logic [1:0] {
    RX_IDLE,
    RX_RECV,
    RX_REPORT
  } rx_state_t;

endpackage

// File: rtl/sort_rx.sv
// sort_rx: stream sink for the sorter output. It consumes one frame at a time,
// checks that the frame is monotonic in the direction chosen by desc, counts
// the beats (saturating at 2**ADDRESS) and publishes a one-cycle report.
module sort_rx #(
  parameter int WIDTH   = sort_pkg::WIDTH,
  parameter int ADDRESS = sort_pkg::ADDRESS
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [WIDTH-1:0]   idata,
  input  logic               ivalid,
  input  logic               ilast,
  output logic               iready,
  input  logic               sink_en,
  input  logic               desc,
  output logic               frame_done,
  output logic [ADDRESS:0]   frame_len,
  output logic               order_err,
  output logic [ADDRESS:0]   err_index,
  output logic               overflow_err,
  output logic [WIDTH-1:0]   first_data,
  output logic [WIDTH-1:0]   last_data,
  output logic [15:0]        frame_cnt
);

  import sort_pkg::*;

  localparam int CW = ADDRESS + 1;
  localparam logic [CW-1:0] CAP = {1'b1, {ADDRESS{1'b0}}};

  rx_state_t        state, state_nx;
  logic             accept;
  logic             viol;

  // Working registers for the frame being received.
  logic [CW-1:0]    cnt, cnt_nx;
  logic [CW-1:0]    w_idx, w_idx_nx;
  logic             w_err, w_err_nx;
  logic             w_ovf, w_ovf_nx;
  logic             w_desc, w_desc_nx;
  logic [WIDTH-1:0] w_first, w_first_nx;
  logic [WIDTH-1:0] prev;

  // Ready depends only on state and sink_en, so the sorter never sees a
  // combinational path from its own valid back into ready.
  assign iready = sink_en & (state != RX_REPORT);
  assign accept = ivalid & iready;

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= RX_IDLE;
    else        state <= state_nx;
  end

  // Next-state decode and report strobe.
  // NOTE: every output of a combinational block gets a default first, so no
  // path through the case leaves a value unassigned and no latch is inferred.
  always_comb begin
    state_nx   = state;
    frame_done = 1'b0;
    unique case (state)
      RX_IDLE:   if (accept) state_nx = ilast ? RX_REPORT : RX_RECV;
      RX_RECV:   if (accept && ilast) state_nx = RX_REPORT;
      RX_REPORT: begin
        frame_done = 1'b1;
        state_nx   = RX_IDLE;
      end
      default:   state_nx = RX_IDLE;
    endcase
  end

  // Working-register update for one accepted beat: first beat restarts the
  // frame, later beats check ordering and advance the saturating count.
  always_comb begin
    viol       = w_desc ? (idata > prev) : (idata < prev);
    cnt_nx     = cnt;
    w_idx_nx   = w_idx;
    w_err_nx   = w_err;
    w_ovf_nx   = w_ovf;
    w_desc_nx  = w_desc;
    w_first_nx = w_first;
    if (accept) begin
      if (state == RX_IDLE) begin
        cnt_nx     = CW'(1);
        w_idx_nx   = '0;
        w_err_nx   = 1'b0;
        w_ovf_nx   = 1'b0;
        w_desc_nx  = desc;
        w_first_nx = idata;
      end else begin
        // cnt equals the 0-based index of this beat until it saturates.
        if (viol && !w_err) begin
          w_err_nx = 1'b1;
          w_idx_nx = cnt;
        end
        if (cnt == CAP) w_ovf_nx = 1'b1;
        else            cnt_nx   = cnt + CW'(1);
      end
    end
  end

  // Working registers advance only on accepted beats.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt     <= '0;
      w_idx   <= '0;
      w_err   <= 1'b0;
      w_ovf   <= 1'b0;
      w_desc  <= 1'b0;
      w_first <= '0;
      prev    <= '0;
    end else if (accept) begin
      cnt     <= cnt_nx;
      w_idx   <= w_idx_nx;
      w_err   <= w_err_nx;
      w_ovf   <= w_ovf_nx;
      w_desc  <= w_desc_nx;
      w_first <= w_first_nx;
      prev    <= idata;
    end
  end

  // Report registers load together as the last beat is taken (entry to REPORT).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      frame_len    <= '0;
      order_err    <= 1'b0;
      err_index    <= '0;
      overflow_err <= 1'b0;
      first_data   <= '0;
      last_data    <= '0;
    end else if (accept && ilast) begin
      frame_len    <= cnt_nx;
      order_err    <= w_err_nx;
      err_index    <= w_idx_nx;
      overflow_err <= w_ovf_nx;
      first_data   <= w_first_nx;
      last_data    <= idata;
    end
  end

  // Completed-frame counter, bumped in the REPORT cycle; wraps naturally.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                  frame_cnt <= '0;
    else if (state == RX_REPORT) frame_cnt <= frame_cnt + 16'd1;
  end

endmodule

// File: tb/tb_sort_rx.sv
// Self-checking bench for sort_rx: directed frames with literal expectations
// plus randomized frames compared every cycle against a frame-level model.
`timescale 1ns/1ps
module tb_sort_rx;

  localparam int WIDTH   = 8;
  localparam int ADDRESS = 3;
  localparam int CAP     = 8;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic [WIDTH-1:0] idata = '0;
  logic             ivalid = 1'b0;
  logic             ilast = 1'b0;
  logic             sink_en = 1'b1;
  logic             desc = 1'b0;
  logic             iready;
  logic             frame_done;
  logic [ADDRESS:0] frame_len;
  logic             order_err;
  logic [ADDRESS:0] err_index;
  logic             overflow_err;
  logic [WIDTH-1:0] first_data;
  logic [WIDTH-1:0] last_data;
  logic [15:0]      frame_cnt;

  sort_rx #(.WIDTH(WIDTH), .ADDRESS(ADDRESS)) dut (
    .clk(clk), .reset(reset), .idata(idata), .ivalid(ivalid), .ilast(ilast),
    .iready(iready), .sink_en(sink_en), .desc(desc), .frame_done(frame_done),
    .frame_len(frame_len), .order_err(order_err), .err_index(err_index),
    .overflow_err(overflow_err), .first_data(first_data), .last_data(last_data),
    .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- frame-level reference model ----------------
  logic [WIDTH-1:0] mq[$];
  bit               m_desc = 0;
  bit               m_report = 0;
  logic [ADDRESS:0] e_len = '0, e_idx = '0;
  bit               e_err = 0, e_ovf = 0;
  logic [WIDTH-1:0] e_first = '0, e_last = '0;
  logic [15:0]      e_cnt = '0;

  task automatic m_clear();
    mq.delete();
    m_desc = 0; m_report = 0;
    e_len = '0; e_idx = '0; e_err = 0; e_ovf = 0;
    e_first = '0; e_last = '0; e_cnt = '0;
  endtask

  // Whole-frame evaluation from the list of accepted words.
  task automatic m_finish_frame();
    int n;
    n       = mq.size();
    e_len   = (ADDRESS+1)'((n > CAP) ? CAP : n);
    e_ovf   = (n > CAP);
    e_first = mq[0];
    e_last  = mq[n-1];
    e_err   = 0;
    e_idx   = '0;
    for (int i = 1; i < n; i++) begin
      if (!e_err && (m_desc ? (mq[i] > mq[i-1]) : (mq[i] < mq[i-1]))) begin
        e_err = 1;
        e_idx = (ADDRESS+1)'((i > CAP) ? CAP : i);
      end
    end
    mq.delete();
  endtask

  // Compare process: mid-cycle, check DUT against model, then advance model
  // by what the coming clock edge will do.
  always @(negedge clk) begin
    if (!reset) m_clear();
    check("iready",       iready,       m_report ? 1'b0 : sink_en);
    check("frame_done",   frame_done,   m_report);
    check("frame_len",    frame_len,    e_len);
    check("order_err",    order_err,    e_err);
    check("err_index",    err_index,    e_idx);
    check("overflow_err", overflow_err, e_ovf);
    check("first_data",   first_data,   e_first);
    check("last_data",    last_data,    e_last);
    check("frame_cnt",    frame_cnt,    e_cnt);
    if (reset) begin
      if (m_report) begin
        m_report = 0;
        e_cnt++;
      end else if (ivalid && sink_en) begin
        if (mq.size() == 0) m_desc = desc;
        mq.push_back(idata);
        if (ilast) begin
          m_finish_frame();
          m_report = 1;
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  bit   sink_rand = 0;
  bit   gap_rand = 0;
  logic sink_seq[$];

  task automatic next_sink();
    if (sink_seq.size() > 0) sink_en = sink_seq.pop_front();
    else if (sink_rand)      sink_en = ($urandom_range(0, 3) != 0);
    else                     sink_en = 1'b1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    next_sink();
  endtask

  // Drive one frame; returns total stall cycles and stalls on the first beat.
  task automatic send_frame(input logic [WIDTH-1:0] d[$], input logic dsc,
                            input bit hold_valid, input bit no_last,
                            output int waits, output int first_waits);
    bit taken;
    int budget;
    waits = 0;
    first_waits = 0;
    for (int i = 0; i < d.size(); i++) begin
      if (gap_rand && i > 0 && $urandom_range(0, 4) == 0) begin
        ivalid = 1'b0;
        ilast  = 1'b0;
        tick();
      end
      idata  = d[i];
      ivalid = 1'b1;
      ilast  = (i == d.size() - 1) && !no_last;
      desc   = (i == 0) ? dsc : logic'($urandom_range(0, 1));
      taken  = 0;
      budget = 0;
      while (!taken) begin
        @(negedge clk);
        taken = iready;
        tick();
        if (!taken) begin
          waits++;
          if (i == 0) first_waits++;
          budget++;
          if (budget > 64) begin
            vectors++;
            miscompares++;
            $display("FAIL handshake_timeout: beat %0d not taken after %0d cycles", i, budget);
            ivalid = 1'b0;
            return;
          end
        end
      end
    end
    if (!hold_valid) begin
      ivalid = 1'b0;
      ilast  = 1'b0;
    end
  endtask

  task automatic pulse_reset();
    ivalid = 1'b0;
    ilast  = 1'b0;
    reset  = 1'b0;
    @(negedge clk);
    check("rst frame_cnt",  frame_cnt,  0);
    check("rst frame_len",  frame_len,  0);
    check("rst first_data", first_data, 0);
    check("rst frame_done", frame_done, 0);
    tick();
    reset = 1'b1;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // ---------------- main sequence ----------------
  initial begin
    logic [WIDTH-1:0] fr[$];
    logic [WIDTH-1:0] fr2[$];
    int w, fw, len, mode, a, b;
    logic dsc;
    logic [WIDTH-1:0] tmp;

    reset = 1'b0;
    sink_en = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset iready",    iready,    1);
    check("reset frame_cnt", frame_cnt, 0);
    check("reset frame_len", frame_len, 0);
    tick();
    reset = 1'b1;

    // Descending frame 9,7,7,3.
    fr = '{8'd9, 8'd7, 8'd7, 8'd3};
    send_frame(fr, 1'b1, 0, 0, w, fw);
    @(negedge clk);
    check("t1 frame_done", frame_done, 1);
    check("t1 frame_len",  frame_len,  4);
    check("t1 order_err",  order_err,  0);
    check("t1 first_data", first_data, 9);
    check("t1 last_data",  last_data,  3);
    tick();
    @(negedge clk);
    check("t1 frame_cnt",  frame_cnt,  1);
    check("t1 done_gone",  frame_done, 0);
    tick();

    // Descending with violations at index 2 and 4.
    fr = '{8'd5, 8'd4, 8'd6, 8'd2, 8'd8};
    send_frame(fr, 1'b1, 0, 0, w, fw);
    @(negedge clk);
    check("t2 order_err", order_err, 1);
    check("t2 err_index", err_index, 2);
    check("t2 frame_len", frame_len, 5);
    tick();

    // 10-beat frame into an 8-word capacity.
    fr.delete();
    for (int i = 0; i < 10; i++) fr.push_back(WIDTH'(100 - i));
    send_frame(fr, 1'b1, 0, 0, w, fw);
    @(negedge clk);
    check("t3 overflow_err", overflow_err, 1);
    check("t3 frame_len",    frame_len,    8);
    check("t3 last_data",    last_data,    91);
    check("t3 stalls",       w,            0);
    tick();

    // sink_en 1,0,0,1 with valid held.
    sink_en = 1'b1;
    sink_seq = '{1'b0, 1'b0, 1'b1};
    fr = '{8'd1, 8'd2, 8'd3, 8'd4};
    send_frame(fr, 1'b0, 0, 0, w, fw);
    check("t4 stalls", w, 2);
    @(negedge clk);
    check("t4 frame_len",  frame_len,  4);
    check("t4 first_data", first_data, 1);
    check("t4 last_data",  last_data,  4);
    check("t4 order_err",  order_err,  0);
    tick();

    // Back-to-back frames after a fresh reset.
    pulse_reset();
    fr  = '{8'd3, 8'd3};
    fr2 = '{8'd10, 8'd20, 8'd30};
    send_frame(fr, 1'b0, 1, 0, w, fw);
    send_frame(fr2, 1'b0, 0, 0, w, fw);
    check("t5 first_beat_stall", fw, 1);
    @(negedge clk);
    check("t5 frame_len",  frame_len,  3);
    check("t5 first_data", first_data, 10);
    tick();
    @(negedge clk);
    check("t5 frame_cnt", frame_cnt, 2);
    tick();

    // Reset after two beats of a frame, then a 3-beat frame.
    fr = '{8'd40, 8'd41};
    send_frame(fr, 1'b0, 0, 1, w, fw);
    pulse_reset();
    fr = '{8'd7, 8'd8, 8'd9};
    send_frame(fr, 1'b0, 0, 0, w, fw);
    @(negedge clk);
    check("t6 frame_len", frame_len, 3);
    tick();
    @(negedge clk);
    check("t6 frame_cnt", frame_cnt, 1);
    tick();

    // Randomized frames against the model.
    sink_rand = 1;
    gap_rand  = 1;
    for (int f = 0; f < 300; f++) begin
      len  = $urandom_range(1, 11);
      dsc  = logic'($urandom_range(0, 1));
      mode = $urandom_range(0, 2);
      fr.delete();
      for (int i = 0; i < len; i++) fr.push_back(WIDTH'($urandom_range(0, 15)));
      if (mode != 0) begin
        if (dsc) fr.rsort();
        else     fr.sort();
        if (mode == 2 && len > 1) begin
          a = $urandom_range(0, len - 1);
          b = $urandom_range(0, len - 1);
          tmp = fr[a]; fr[a] = fr[b]; fr[b] = tmp;
        end
      end
      if ($urandom_range(0, 39) == 0) begin
        send_frame(fr, dsc, 0, 1, w, fw);
        pulse_reset();
      end else begin
        send_frame(fr, dsc, bit'($urandom_range(0, 1)), 0, w, fw);
        if (!ivalid) repeat ($urandom_range(0, 2)) tick();
      end
    end

    sink_rand = 0;
    ivalid = 1'b0;
    ilast  = 1'b0;
    repeat (4) tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
